multiply_add: RTL and testbench

//   Sequential shift-add multiply-accumulate: product = multiplicand * multiplier + addend.

---
 rtl/multiply_add_if.sv | 23 ++
 rtl/multiply_add.sv | 108 ++++++++++
 tb/tb_multiply_add.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/multiply_add_if.sv
// Operand/result bundle for the shift-add multiply-accumulate unit.
// The master issues start with its operands; the slave returns done, overflow and product.
interface multiply_add_if #(
    parameter int SIZE = 32
);
    logic            start;
    logic [SIZE-1:0] multiplicand;
    logic [SIZE-1:0] multiplier;
    logic [SIZE-1:0] addend;
    logic            done;
    logic            overflow;
    logic [SIZE-1:0] product;

    modport master (
        output start, multiplicand, multiplier, addend,
        input  done, overflow, product
    );

    modport slave (
        input  start, multiplicand, multiplier, addend,
        output done, overflow, product
    );
endinterface

// File: rtl/multiply_add.sv
// Sequential shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// One result every SIZE+2 cycles; a double-width accumulator keeps the full result exact.
//
// state | meaning
// IDLE  | waiting for start; operands are loaded on the accepting edge
// RUN   | one shift-add step per cycle, SIZE steps counted down to zero
// DONE  | result registered into product/overflow with a one-cycle done pulse
module multiply_add #(
    parameter int SIZE = 32
) (
    input  logic          clk,
    input  logic          reset,
    multiply_add_if.slave bus
);
    localparam int CNT_W = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q,    state_d;
    logic [2*SIZE-1:0]   acc_q,      acc_d;
    logic [2*SIZE-1:0]   mcand_q,    mcand_d;
    logic [SIZE-1:0]     mplier_q,   mplier_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                done_q,     done_d;
    logic                overflow_q, overflow_d;
    logic [SIZE-1:0]     product_q,  product_d;

    logic                last_step;

    // The step that consumes the final multiplier bit is the one seen with cnt == 1.
    assign last_step = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            product_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            product_q  <= product_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        product_d  = product_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d    = {{SIZE{1'b0}}, bus.addend};
                    mcand_d  = {{SIZE{1'b0}}, bus.multiplicand};
                    mplier_d = bus.multiplier;
                    cnt_d    = CNT_W'(SIZE);
                    state_d  = RUN;
                end
            end

            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (last_step) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                product_d  = acc_q[SIZE-1:0];
                overflow_d = |acc_q[2*SIZE-1:SIZE];
                done_d     = 1'b1;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.product  = product_q;
endmodule

// File: tb/tb_multiply_add.sv
// Scoreboard bench for multiply_add: the driver queues expected results with their due cycle,
// and a negedge monitor matches every done pulse and checks that results hold in between.
module tb_multiply_add;
    localparam int SIZE = 32;
    localparam int LAT  = SIZE + 1;
    localparam int GAP  = SIZE + 2;

    typedef struct {
        logic [SIZE-1:0] p;
        logic            ov;
        int              dc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multiply_add_if #(.SIZE(SIZE)) bus ();
    multiply_add #(.SIZE(SIZE)) dut (.clk(clk), .reset(reset), .bus(bus));

    int              cyc = 0;
    int              n_checks = 0;
    int              n_fail = 0;
    int              next_free = 0;
    bit              armed = 1'b0;
    exp_t            sb[$];
    logic [SIZE-1:0] last_p = '0;
    logic            last_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: exact double-width arithmetic, then split into low word and overflow flag.
    function automatic void ref_model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                      input logic [SIZE-1:0] c,
                                      output logic [SIZE-1:0] p, output logic ov);
        logic [2*SIZE-1:0] full;
        full = (2*SIZE)'(a) * (2*SIZE)'(b) + (2*SIZE)'(c);
        p    = full[SIZE-1:0];
        ov   = (full >> SIZE) != 0;
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(bus.done), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product",    64'(bus.product),  64'(e.p));
                    check("overflow",   64'(bus.overflow), 64'(e.ov));
                    check("done_cycle", 64'(cyc),          64'(e.dc));
                    last_p  = e.p;
                    last_ov = e.ov;
                end
            end else begin
                if (sb.size() > 0 && sb[0].dc <= cyc) begin
                    check("done_missing", 64'(bus.done), 64'(1));
                    void'(sb.pop_front());
                end
                check("hold_product",  64'(bus.product),  64'(last_p));
                check("hold_overflow", 64'(bus.overflow), 64'(last_ov));
            end
        end
    end

    task automatic wait_free();
        while (cyc + 1 < next_free) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                         input logic [SIZE-1:0] c, input logic [SIZE-1:0] p, input logic ov);
        wait_free();
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.addend       = c;
        sb.push_back('{p: p, ov: ov, dc: cyc + 1 + LAT});
        next_free = cyc + 1 + GAP;
        @(posedge clk);
        #1;
        bus.start        = 1'b0;
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
        bus.addend       = $urandom;
    endtask

    task automatic issue_model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                               input logic [SIZE-1:0] c);
        logic [SIZE-1:0] p;
        logic            ov;
        ref_model(a, b, c, p, ov);
        issue(a, b, c, p, ov);
    endtask

    // start held high with operands changing every cycle: only accepting edges count.
    task automatic held_start(input int n);
        logic [SIZE-1:0] p;
        logic            ov;
        wait_free();
        for (int i = 0; i < n; i++) begin
            bus.start        = 1'b1;
            bus.multiplicand = $urandom;
            bus.multiplier   = $urandom;
            bus.addend       = $urandom;
            if (cyc + 1 >= next_free) begin
                ref_model(bus.multiplicand, bus.multiplier, bus.addend, p, ov);
                sb.push_back('{p: p, ov: ov, dc: cyc + 1 + LAT});
                next_free = cyc + 1 + GAP;
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 100000", cyc);
        $fatal(1);
    end

    initial begin
        logic [SIZE-1:0] dividend, divisor, quo, rem, a, b;
        int t;

        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.addend       = '0;
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b0;
        last_p    = '0;
        last_ov   = 1'b0;
        armed     = 1'b1;
        next_free = cyc + 1;
        @(negedge clk);
        check("reset_done", 64'(bus.done), 64'(0));
        @(posedge clk);
        #1;

        issue(32'd7, 32'd6, 32'd5, 32'd47, 1'b0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        issue(32'h0000_FFFF, 32'h0001_0001, 32'd0, 32'hFFFF_FFFF, 1'b0);
        issue(32'h0001_0000, 32'h0001_0000, 32'd0, 32'h0000_0000, 1'b1);
        issue(32'd0, 32'hDEAD_BEEF, 32'd1234, 32'd1234, 1'b0);
        issue(32'hCAFE_F00D, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(32'd142, 32'd7, 32'd6, 32'd1000, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            dividend = $urandom;
            divisor  = $urandom >> $urandom_range(0, 31);
            if (divisor == 0) divisor = 32'd1;
            quo = dividend / divisor;
            rem = dividend % divisor;
            issue(quo, divisor, rem, dividend, 1'b0);
        end

        for (int i = 0; i < 200; i++) begin
            a = $urandom >> $urandom_range(0, 31);
            b = $urandom >> $urandom_range(0, 31);
            issue_model(a, b, $urandom);
        end

        held_start(3 * GAP + 5);

        // Abort an operation halfway through RUN.
        issue_model($urandom, $urandom, $urandom);
        repeat (SIZE / 2 - 1) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        sb.delete();
        last_p  = '0;
        last_ov = 1'b0;
        #1;
        reset     = 1'b0;
        next_free = cyc + 1;
        @(negedge clk);
        check("abort_done",     64'(bus.done),     64'(0));
        check("abort_product",  64'(bus.product),  64'(0));
        check("abort_overflow", 64'(bus.overflow), 64'(0));
        @(posedge clk);
        #1;
        issue(32'd3, 32'd4, 32'd1, 32'd13, 1'b0);

        t = 0;
        while (sb.size() > 0 && t < 4 * GAP) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() > 0) check("drain_timeout", 64'(sb.size()), 64'(0));
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
